// File: rtl/frame_buffer.sv
// ---------------------------------------------------------------------------
// frame_buffer
//
// Pixel store and scan-out engine. Single-pixel writes arrive from the sprite
// command controller while idle. A draw request streams the whole frame, in
// index order, to the display over a valid/ready pixel interface. fb_busy is
// high for the whole transfer.
//
// Optional feature macro: FB_CLEAR_ON_DRAW_EN
//   defined   - every accepted scan-out pixel is overwritten with 24'h000000
//               on its handshake edge, leaving a blank frame after a draw.
//   undefined - scan-out is read-only and contents persist across draws.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   fb_wfb            pixel write strobe (honoured only while idle)
//   fb_dfb            draw request strobe (honoured only while idle)
//   fb_px             write pixel index {y,x}
//   fb_r/fb_g/fb_b    write colour
//   fb_busy           high while a scan-out is in progress
//   fb_wr_dropped     one-cycle pulse after a write arrived while busy
//   out_valid/ready   scan-out pixel handshake
//   out_px            index of the presented pixel
//   out_r/g/b         presented colour
//   out_sof/out_eof   first / last pixel of the frame (qualified by valid)
// ---------------------------------------------------------------------------
module frame_buffer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fb_wfb,
  input  logic              fb_dfb,
  input  logic [ADDR_W-1:0] fb_px,
  input  logic [7:0]        fb_r,
  input  logic [7:0]        fb_g,
  input  logic [7:0]        fb_b,
  output logic              fb_busy,
  output logic              fb_wr_dropped,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_px,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic              out_sof,
  output logic              out_eof
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_t;

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_nextCnt;
  logic [23:0]         r_mem [0:DEPTH-1];
  logic [23:0]         r_rdData;
  logic                r_wrDropped;
  logic                w_handshake;
  logic                w_memWe;
  logic [ADDR_W-1:0]   w_memAddr;
  logic [23:0]         w_memWdata;

  assign w_handshake = (r_state == SEND) && out_ready;

  // State and pixel counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Next-state logic. The counter stops on the last index instead of
  // wrapping, so out_px keeps pointing at the final pixel until the next draw.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (fb_dfb) begin
          w_nextState = FETCH;
          w_nextCnt   = '0;
        end
      end
      FETCH: begin
        w_nextState = SEND;
      end
      SEND: begin
        if (w_handshake) begin
          if (r_cnt == LAST) begin
            w_nextState = IDLE;
          end else begin
            w_nextState = FETCH;
            w_nextCnt   = r_cnt + ADDR_W'(1);
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Single write port. Host writes can only happen in IDLE and the optional
  // clear only on a SEND handshake, so the two sources never collide.
  always_comb begin
    w_memWe    = (r_state == IDLE) && fb_wfb;
    w_memAddr  = fb_px;
    w_memWdata = {fb_r, fb_g, fb_b};
`ifdef FB_CLEAR_ON_DRAW_EN
    if (w_handshake) begin
      w_memWe    = 1'b1;
      w_memAddr  = r_cnt;
      w_memWdata = 24'h000000;
    end
`endif
  end

  // Pixel memory; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memWdata;
    end
  end

  // Synchronous read issued in FETCH. A write on the draw-request edge lands
  // a cycle before this read, so the stream sees the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdData <= '0;
    end else if (r_state == FETCH) begin
      r_rdData <= r_mem[r_cnt];
    end
  end

  // Writes that arrive during a scan-out are discarded and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrDropped <= 1'b0;
    end else begin
      r_wrDropped <= fb_wfb && (r_state != IDLE);
    end
  end

  assign fb_busy       = (r_state != IDLE);
  assign fb_wr_dropped = r_wrDropped;
  assign out_valid     = (r_state == SEND);
  assign out_px        = r_cnt;
  assign out_r         = r_rdData[23:16];
  assign out_g         = r_rdData[15:8];
  assign out_b         = r_rdData[7:0];
  assign out_sof       = out_valid && (r_cnt == '0);
  assign out_eof       = out_valid && (r_cnt == LAST);

endmodule

// File: doc/frame_buffer.md
# frame_buffer

Pixel store and scan-out engine on the responder side of the sprite/frame-buffer write interface (`fb_wfb`, `fb_dfb`, `fb_px`, `fb_r/g/b`, `fb_busy`). It accepts single-pixel writes from the sprite command controller. On a draw request it streams the whole frame, in index order, to the display side over a valid/ready pixel interface, holding `fb_busy` high for the whole transfer. It sits between the sprite command controller (upstream) and the display/video output (downstream).

## Interface
- `ADDR_W`, default 16: pixel index width. The frame holds 2^ADDR_W pixels and the index is `{y,x}`. Simulation may use smaller values.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `fb_wfb`  in  1  pixel write strobe.
- `fb_dfb`  in  1  draw (scan-out) request strobe.
- `fb_px`  in  ADDR_W  write pixel index.
- `fb_r`, `fb_g`, `fb_b`  in  8 each  write colour.
- `fb_busy`  out  1  high while a scan-out is in progress.
- `fb_wr_dropped`  out  1  one-cycle pulse when a write is discarded.
- `out_valid`  out  1  scan-out pixel valid.
- `out_ready`  in  1  display accepts the pixel.
- `out_px`  out  ADDR_W  index of the presented pixel.
- `out_r`, `out_g`, `out_b`  out  8 each  presented colour.
- `out_sof`, `out_eof`  out  1 each  qualify the first and last pixel of a frame (valid only with `out_valid`).

## Operation
- Storage: 2^ADDR_W × 24-bit memory, one synchronous read port and one write port. Contents are not reset.
- States:
  - IDLE: `fb_busy`=0.
  - FETCH: issue a read at `cnt`.
  - SEND: present the read data and hold until the handshake.
- IDLE transitions:
  - `fb_wfb`: writes `{fb_r,fb_g,fb_b}` to `fb_px` on that edge.
  - `fb_dfb`: `cnt`←0, go to FETCH.
  - Both asserted together: the write is performed and the scan-out starts. The stream contains the new value.
- FETCH: always 1 cycle, then go to SEND.
- SEND:
  - `out_valid`=1, with `out_px`=`cnt` and the colour held stable until `out_valid && out_ready`.
  - On the handshake, if `cnt`==2^ADDR_W−1 go to IDLE; else `cnt`←`cnt`+1 and go to FETCH.
  - `cnt` is ADDR_W bits and never wraps within a frame.
- `out_sof` = (`cnt`==0). `out_eof` = (`cnt`==all ones).
- `fb_wfb` while `fb_busy`: the write is discarded and `fb_wr_dropped` pulses on the next cycle.
- `fb_dfb` while `fb_busy`: ignored, with no pulse and no restart.
- Reset, including mid-frame:
  - State→IDLE, `cnt`→0.
  - All outputs 0: `fb_busy`, `fb_wr_dropped`, `out_valid`, `out_sof`, `out_eof`, `out_px`, `out_r/g/b`.
  - Memory is untouched.

## Timing
- Write latency: data is written at the edge where `fb_wfb` is sampled. A scan-out starting on the same edge reads it.
- Cycle N with `fb_dfb` high in IDLE:
  - N+1: FETCH, `fb_busy`=1 (registered). The controller polls busy on N+1 and sees 1.
  - N+2: SEND, `out_valid`=1 for pixel 0.
- Per pixel: 1 FETCH cycle, then ≥1 SEND cycle.
- With `out_ready` tied high: `fb_busy` is high for exactly 2·2^ADDR_W cycles, and `out_valid` toggles every cycle.
- After the last handshake at edge M, `fb_busy`=0 from cycle M+1. Writes are accepted from M+1.
- `out_valid` never drops without a handshake, and the data does not change while stalled.

## Configuration
- `FB_CLEAR_ON_DRAW_EN`:
  - Defined: on each SEND handshake, the pixel at `cnt` is written to 24'h000000 on that edge. After a scan-out the frame is all zero, ready for the next frame composition.
  - Undefined: scan-out is read-only and contents persist across draws.

## Test plan
- ADDR_W=4. Write px 0..15 with colour {px,px,px}, `out_ready`=1, pulse `fb_dfb` → 16 beats with `out_px` 0..15 and colour {i,i,i}; `out_sof` on beat 0, `out_eof` on beat 15; `fb_busy` high for exactly 32 cycles.
- `fb_wfb` (px 3, 0xAABBCC) and `fb_dfb` in the same cycle → beat 3 carries 0xAABBCC; `fb_busy` is 1 on the next cycle.
- `fb_wfb` to px 5 during scan-out → `fb_wr_dropped` pulses once, px 5 is unchanged on the next frame, and `fb_dfb` mid-frame causes no restart.
- `out_ready` low for 7 cycles on beat 9 → `out_valid`, `out_px`=9 and colour held constant; the frame completes with 16 beats and no duplicates.
- Assert `rst` during beat 6 → all outputs 0 on the following cycle. A new `fb_dfb` restarts at px 0, and the memory still holds prior values.
- `FB_CLEAR_ON_DRAW_EN` defined: two back-to-back draws → the first frame shows the written data, the second frame is all 0x000000. Undefined: both frames are identical.
